// File: rtl/lse_sched_if.sv
// Bundles the buffer-read, LSE and estimate-write buses between the LSE
// sequencer (master) and its surrounding memories and multiplier (slave).
interface lse_sched_if #(
  parameter int DMRS_RX_WORD_LENGTH    = 12,
  parameter int DMRS_TX_WORD_LENGTH    = 5,
  parameter int CH_EST_LSE_WORD_LENGTH = 16,
  parameter int ADDR_W                 = 8
) ();

  logic                              rx_rd_en;
  logic [ADDR_W-1:0]                 rx_rd_addr;
  logic [DMRS_RX_WORD_LENGTH-1:0]    rx_rd_i;
  logic [DMRS_RX_WORD_LENGTH-1:0]    rx_rd_q;

  logic                              tx_rd_en;
  logic [ADDR_W-1:0]                 tx_rd_addr;
  logic [DMRS_TX_WORD_LENGTH-1:0]    tx_rd_i;
  logic [DMRS_TX_WORD_LENGTH-1:0]    tx_rd_q;

  logic                              lse_in_valid;
  logic [DMRS_RX_WORD_LENGTH-1:0]    lse_rx_i;
  logic [DMRS_RX_WORD_LENGTH-1:0]    lse_rx_q;
  logic [DMRS_TX_WORD_LENGTH-1:0]    lse_tx_i;
  logic [DMRS_TX_WORD_LENGTH-1:0]    lse_tx_q;

  logic                              lse_out_valid;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] lse_est_i;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] lse_est_q;

  logic                              est_wr_en;
  logic [ADDR_W-1:0]                 est_wr_addr;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] est_wr_i;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] est_wr_q;

  modport master (
    output rx_rd_en, rx_rd_addr,
    input  rx_rd_i, rx_rd_q,
    output tx_rd_en, tx_rd_addr,
    input  tx_rd_i, tx_rd_q,
    output lse_in_valid, lse_rx_i, lse_rx_q, lse_tx_i, lse_tx_q,
    input  lse_out_valid, lse_est_i, lse_est_q,
    output est_wr_en, est_wr_addr, est_wr_i, est_wr_q
  );

  modport slave (
    input  rx_rd_en, rx_rd_addr,
    output rx_rd_i, rx_rd_q,
    input  tx_rd_en, tx_rd_addr,
    output tx_rd_i, tx_rd_q,
    input  lse_in_valid, lse_rx_i, lse_rx_q, lse_tx_i, lse_tx_q,
    output lse_out_valid, lse_est_i, lse_est_q,
    input  est_wr_en, est_wr_addr, est_wr_i, est_wr_q
  );

endinterface

// File: rtl/lse_sched.sv
// LSE channel-estimation sequencer for one PBCH DMRS block: reads rx/ref
// DMRS pairs, streams them to the LSE multiplier and writes the estimates.
module lse_sched #(
  parameter int DMRS_RX_WORD_LENGTH    = 12,
  parameter int DMRS_TX_WORD_LENGTH    = 5,
  parameter int CH_EST_LSE_WORD_LENGTH = 16,
  parameter int ADDR_W                 = 8,
  parameter int MAX_RE                 = 144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_re,
  input  logic              est_ready,
  output logic              busy,
  output logic              done,
  lse_sched_if.master       bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] MAX_RE_C = ADDR_W'(MAX_RE);

  state_t                            state_q, state_d;
  logic [ADDR_W-1:0]                 n_q, n_d;
  logic [ADDR_W-1:0]                 issue_q, issue_d;
  logic [ADDR_W-1:0]                 wr_cnt_q, wr_cnt_d;
  logic                              lse_in_valid_q, lse_in_valid_d;
  logic                              est_wr_en_q, est_wr_en_d;
  logic [ADDR_W-1:0]                 est_wr_addr_q, est_wr_addr_d;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] est_wr_i_q, est_wr_i_d;
  logic [CH_EST_LSE_WORD_LENGTH-1:0] est_wr_q_q, est_wr_q_d;
  logic                              rd_en;
  logic [ADDR_W-1:0]                 n_clamp;

  assign n_clamp = (num_re > MAX_RE_C) ? MAX_RE_C : num_re;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    issue_d        = issue_q;
    wr_cnt_d       = wr_cnt_q;
    rd_en          = 1'b0;
    est_wr_en_d    = 1'b0;
    est_wr_addr_d  = est_wr_addr_q;
    est_wr_i_d     = est_wr_i_q;
    est_wr_q_d     = est_wr_q_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n_clamp;
          issue_d  = '0;
          wr_cnt_d = '0;
          state_d  = (n_clamp == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (est_ready) begin
          rd_en   = 1'b1;
          issue_d = issue_q + 1'b1;
          if (issue_d == n_q) state_d = DRAIN;
        end
      end
      // The final write is on the bus in the same cycle wr_cnt reaches n.
      DRAIN: begin
        if ((wr_cnt_q == n_q) && est_wr_en_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    lse_in_valid_d = rd_en;

    if (bus.lse_out_valid && (state_q != IDLE)) begin
      est_wr_en_d   = 1'b1;
      est_wr_addr_d = wr_cnt_q;
      est_wr_i_d    = bus.lse_est_i;
      est_wr_q_d    = bus.lse_est_q;
      wr_cnt_d      = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      issue_q        <= '0;
      wr_cnt_q       <= '0;
      lse_in_valid_q <= 1'b0;
      est_wr_en_q    <= 1'b0;
      est_wr_addr_q  <= '0;
      est_wr_i_q     <= '0;
      est_wr_q_q     <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      issue_q        <= issue_d;
      wr_cnt_q       <= wr_cnt_d;
      lse_in_valid_q <= lse_in_valid_d;
      est_wr_en_q    <= est_wr_en_d;
      est_wr_addr_q  <= est_wr_addr_d;
      est_wr_i_q     <= est_wr_i_d;
      est_wr_q_q     <= est_wr_q_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign bus.rx_rd_en   = rd_en;
  assign bus.rx_rd_addr = rd_en ? issue_q : '0;
  assign bus.tx_rd_en   = rd_en;
  assign bus.tx_rd_addr = rd_en ? issue_q : '0;

  // Read data is only meaningful the cycle after a read; zero it otherwise.
  assign bus.lse_in_valid = lse_in_valid_q;
  assign bus.lse_rx_i     = lse_in_valid_q ? bus.rx_rd_i : '0;
  assign bus.lse_rx_q     = lse_in_valid_q ? bus.rx_rd_q : '0;
  assign bus.lse_tx_i     = lse_in_valid_q ? bus.tx_rd_i : '0;
  assign bus.lse_tx_q     = lse_in_valid_q ? bus.tx_rd_q : '0;

  assign bus.est_wr_en   = est_wr_en_q;
  assign bus.est_wr_addr = est_wr_addr_q;
  assign bus.est_wr_i    = est_wr_i_q;
  assign bus.est_wr_q    = est_wr_q_q;

endmodule

// File: tb/tb_lse_sched.sv
// Bench for lse_sched: models the rx/ref buffers and the LSE multiplier
// (rx * conj(ref), one registered stage) and checks every bus cycle.
module tb_lse_sched;

  typedef struct {
    int          num_re;
    int          mode;
    int          pattern;
    int          exp_reads;
    int          exp_writes;
    int          exp_last_rd;
    int          exp_done;
    logic [15:0] exp_first_i;
    logic [15:0] exp_first_q;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_re;
  logic       est_ready;
  logic       busy;
  logic       done;
  logic       inject_valid = 1'b0;

  lse_sched_if bus ();

  lse_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_re    (num_re),
    .est_ready (est_ready),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] rx_mem_i [256];
  logic [11:0] rx_mem_q [256];
  logic [4:0]  tx_mem_i [256];
  logic [4:0]  tx_mem_q [256];

  logic [11:0] rx_i_r = '0, rx_q_r = '0;
  logic [4:0]  tx_i_r = '0, tx_q_r = '0;
  logic        lse_v = 1'b0;
  logic [15:0] lse_ei = '0, lse_eq = '0;

  function automatic logic [15:0] lse_i_of(logic [11:0] ri, logic [11:0] rq,
                                           logic [4:0] ti, logic [4:0] tq);
    int a, b, c, d;
    a = int'($signed(ri)); b = int'($signed(rq));
    c = int'($signed(ti)); d = int'($signed(tq));
    return 16'(a * c + b * d);
  endfunction

  function automatic logic [15:0] lse_q_of(logic [11:0] ri, logic [11:0] rq,
                                           logic [4:0] ti, logic [4:0] tq);
    int a, b, c, d;
    a = int'($signed(ri)); b = int'($signed(rq));
    c = int'($signed(ti)); d = int'($signed(tq));
    return 16'(b * c - a * d);
  endfunction

  // Synchronous-read buffers and the one-cycle LSE multiplier.
  always @(posedge clk) begin
    if (bus.rx_rd_en) begin
      rx_i_r <= rx_mem_i[bus.rx_rd_addr];
      rx_q_r <= rx_mem_q[bus.rx_rd_addr];
    end
    if (bus.tx_rd_en) begin
      tx_i_r <= tx_mem_i[bus.tx_rd_addr];
      tx_q_r <= tx_mem_q[bus.tx_rd_addr];
    end
    lse_v  <= bus.lse_in_valid;
    lse_ei <= lse_i_of(bus.lse_rx_i, bus.lse_rx_q, bus.lse_tx_i, bus.lse_tx_q);
    lse_eq <= lse_q_of(bus.lse_rx_i, bus.lse_rx_q, bus.lse_tx_i, bus.lse_tx_q);
  end

  assign bus.rx_rd_i       = rx_i_r;
  assign bus.rx_rd_q       = rx_q_r;
  assign bus.tx_rd_i       = tx_i_r;
  assign bus.tx_rd_q       = tx_q_r;
  assign bus.lse_out_valid = lse_v | inject_valid;
  assign bus.lse_est_i     = lse_ei;
  assign bus.lse_est_q     = lse_eq;

  int checks = 0;
  int errors = 0;
  int rd_cnt, wr_cnt, done_cnt, done_rel, last_rd, last_wr_rel;
  logic [15:0] first_i, first_q;
  logic prev_done;
  vec_t vecs [5];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fillMem(input int pattern);
    for (int k = 0; k < 256; k++) begin
      if (pattern == 0) begin
        rx_mem_i[k] = 12'd1024;
        rx_mem_q[k] = 12'd512;
        tx_mem_i[k] = 5'd8;
        tx_mem_q[k] = 5'(-8);
      end else begin
        rx_mem_i[k] = 12'(4 * k + 16);
        rx_mem_q[k] = 12'(100 - k);
        tx_mem_i[k] = 5'((k % 7) - 3);
        tx_mem_q[k] = 5'(2 - (k % 5));
      end
    end
  endtask

  function automatic logic ready_for(int rel, int mode);
    if (mode == 0 || rel == 0) return 1'b1;
    return (((rel - 1) / 3) % 2) == 0;
  endfunction

  task automatic checkResetOutputs();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_rd_en", int'({bus.rx_rd_en, bus.tx_rd_en}), 0);
    checkOutput("rst_rd_addr", int'({bus.rx_rd_addr, bus.tx_rd_addr}), 0);
    checkOutput("rst_lse_valid", int'(bus.lse_in_valid), 0);
    checkOutput("rst_lse_data",
                int'(|{bus.lse_rx_i, bus.lse_rx_q, bus.lse_tx_i, bus.lse_tx_q}), 0);
    checkOutput("rst_wr_en", int'(bus.est_wr_en), 0);
    checkOutput("rst_wr_addr", int'(bus.est_wr_addr), 0);
    checkOutput("rst_wr_data", int'({bus.est_wr_i, bus.est_wr_q}), 0);
  endtask

  task automatic monitorCycle(input int rel);
    if (!est_ready) checkOutput("rd_while_stalled", int'(bus.rx_rd_en), 0);
    if (bus.rx_rd_en) begin
      checkOutput("tx_rd_en", int'(bus.tx_rd_en), 1);
      checkOutput("rx_rd_addr", int'(bus.rx_rd_addr), rd_cnt);
      checkOutput("tx_rd_addr", int'(bus.tx_rd_addr), rd_cnt);
      last_rd = int'(bus.rx_rd_addr);
      rd_cnt++;
    end else begin
      checkOutput("tx_rd_en_idle", int'(bus.tx_rd_en), 0);
    end
    if (!bus.lse_in_valid)
      checkOutput("lse_idle_zero",
                  int'(|{bus.lse_rx_i, bus.lse_rx_q, bus.lse_tx_i, bus.lse_tx_q}), 0);
    if (bus.est_wr_en) begin
      checkOutput("est_wr_addr", int'(bus.est_wr_addr), wr_cnt);
      checkOutput("est_wr_i", int'(bus.est_wr_i),
                  int'(lse_i_of(rx_mem_i[wr_cnt], rx_mem_q[wr_cnt], tx_mem_i[wr_cnt], tx_mem_q[wr_cnt])));
      checkOutput("est_wr_q", int'(bus.est_wr_q),
                  int'(lse_q_of(rx_mem_i[wr_cnt], rx_mem_q[wr_cnt], tx_mem_i[wr_cnt], tx_mem_q[wr_cnt])));
      if (wr_cnt == 0) begin
        first_i = bus.est_wr_i;
        first_q = bus.est_wr_q;
      end
      wr_cnt++;
      last_wr_rel = rel;
    end
    if (prev_done) checkOutput("busy_after_done", int'(busy), 0);
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    prev_done = done;
  endtask

  task automatic runBlock(input int n, input int mode, input int pattern,
                          input int restart_rel, input int rst_rel);
    fillMem(pattern);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_rel = -1;
    last_rd = -1; last_wr_rel = -1; first_i = '0; first_q = '0; prev_done = 1'b0;
    for (int rel = 0; rel < 400; rel++) begin
      @(posedge clk);
      #2;
      start     = (rel == 0) || (rel == restart_rel);
      num_re    = (rel == restart_rel) ? 8'd10 : 8'(n);
      est_ready = ready_for(rel, mode);
      if (rst_rel >= 0 && rel == rst_rel) begin
        rst = 1'b0;
        #1;
        checkResetOutputs();
      end
      if (rst_rel >= 0 && rel == rst_rel + 2) rst = 1'b1;
      @(negedge clk);
      monitorCycle(rel);
      if (done_cnt > 0 && rel >= done_rel + 2) break;
      if (rst_rel >= 0 && rel >= rst_rel + 3) break;
    end
    start = 1'b0;
    if (rst_rel < 0 && done_cnt == 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v, input int restart_rel);
    runBlock(v.num_re, v.mode, v.pattern, restart_rel, -1);
    checkOutput("read_count", rd_cnt, v.exp_reads);
    checkOutput("write_count", wr_cnt, v.exp_writes);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("done_cycle", done_rel, v.exp_done);
    if (v.exp_reads > 0) checkOutput("last_rd_addr", last_rd, v.exp_last_rd);
    if (v.exp_writes > 0) begin
      checkOutput("first_est_i", int'(first_i), int'(v.exp_first_i));
      checkOutput("first_est_q", int'(first_q), int'(v.exp_first_q));
      checkOutput("done_after_last_write", done_rel - last_wr_rel, 1);
    end
  endtask

  initial begin
    vecs[0] = '{4,   0, 0, 4,   4,   3,   8,   16'h1000, 16'h3000};
    vecs[1] = '{144, 1, 1, 144, 144, 143, 289, 16'h0098, 16'hFEB4};
    vecs[2] = '{0,   0, 0, 0,   0,   0,   1,   16'h0000, 16'h0000};
    vecs[3] = '{200, 0, 1, 144, 144, 143, 148, 16'h0098, 16'hFEB4};
    vecs[4] = '{1,   1, 1, 1,   1,   0,   5,   16'h0098, 16'hFEB4};

    rst = 1'b1; start = 1'b0; num_re = '0; est_ready = 1'b1;
    #1 rst = 1'b0;
    #1 checkResetOutputs();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d: num_re=%0d mode=%0d", i, vecs[i].num_re, vecs[i].mode);
      applyStimulus(vecs[i], -1);
    end

    $display("[TB] second start during a 4-RE block");
    applyStimulus(vecs[0], 2);

    $display("[TB] reset in the middle of a 10-RE block");
    runBlock(10, 0, 1, -1, 3);
    checkOutput("rst_reads_before", rd_cnt, 2);
    checkOutput("rst_no_writes", wr_cnt, 0);
    checkOutput("rst_no_done", done_cnt, 0);
    applyStimulus('{5, 0, 1, 5, 5, 4, 9, 16'h0098, 16'hFEB4}, -1);

    $display("[TB] stray lse_out_valid while idle");
    @(posedge clk);
    #2 inject_valid = 1'b1;
    @(posedge clk);
    #2 inject_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_lse_ignored", int'(bus.est_wr_en), 0);
    checkOutput("idle_not_busy", int'(busy), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
